// File: rtl/jelly2_fifo_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jelly2_fifo_ram_pkg
//  Description : Shared helpers for the RAM-backed FIFO controller.
//  Revision    : 1.0  initial release
// ============================================================================

package jelly2_fifo_ram_pkg;

   // Wide enough for in-flight reads plus output-buffer occupancy (max 5).
   localparam int c_CNT_W = 4;

   function automatic int calc_lat(input int dout_regs);
      return 1 + ((dout_regs != 0) ? 1 : 0);
   endfunction

   function automatic int calc_idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/jelly2_fifo_ram_ctrl_outbuf.sv
`default_nettype none
// ============================================================================
//  Module      : jelly2_fifo_ram_ctrl_outbuf
//  Description : Small register FIFO that absorbs RAM read latency; head
//                entry drives the output stream.
//  Revision    : 1.0  initial release
// ============================================================================

module jelly2_fifo_ram_ctrl_outbuf
   import jelly2_fifo_ram_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int DATA_WIDTH = 8
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cke,
   input  logic                  capture,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output logic [c_CNT_W-1:0]    count
);

   localparam int                 c_IDX_W = calc_idx_width(DEPTH);
   localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);
   localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_IDX_W-1:0]    r_wr_idx;
   logic [c_IDX_W-1:0]    r_rd_idx;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  w_push;
   logic                  w_pop;

   function automatic logic [c_IDX_W-1:0] next_idx(input logic [c_IDX_W-1:0] idx);
      return (idx == c_LAST) ? '0 : idx + c_IDX_W'(1);
   endfunction

   assign w_push = cke & capture;
   assign w_pop  = cke & pop & (r_cnt != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_idx <= '0;
         r_rd_idx <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_idx] <= din;
            r_wr_idx        <= next_idx(r_wr_idx);
         end
         if (w_pop) begin
            r_rd_idx <= next_idx(r_rd_idx);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + c_ONE;
            2'b01:   r_cnt <= r_cnt - c_ONE;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_idx];
   assign valid = (r_cnt != '0);
   assign count = r_cnt;

endmodule

`default_nettype wire

// File: rtl/jelly2_fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jelly2_fifo_ram_ctrl
//  Description : Single-clock FIFO controller for an external simple
//                dual-port RAM; hides the RAM read latency behind a small
//                output buffer. Optional JELLY2_FIFO_RAM_CTRL_COUNT_EN adds
//                data_count/free_count outputs.
//  Revision    : 1.0  initial release
// ============================================================================

module jelly2_fifo_ram_ctrl
   import jelly2_fifo_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 8,
   parameter int DOUT_REGS  = 0
)(
   input  logic                  reset_n,
   input  logic                  clk,
   input  logic                  cke,

   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,

   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,

   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_din,
   output logic                  ram_rd_en,
   output logic                  ram_rd_regcke,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_dout
`ifdef JELLY2_FIFO_RAM_CTRL_COUNT_EN
   ,
   output logic [ADDR_WIDTH:0]   data_count,
   output logic [ADDR_WIDTH:0]   free_count
`endif
);

   typedef logic [ADDR_WIDTH:0] ptr_t;

   localparam int                 c_LAT       = calc_lat(DOUT_REGS);
   localparam int                 c_BUF_DEPTH = c_LAT + 1;
   localparam logic [c_CNT_W-1:0] c_CREDIT    = c_CNT_W'(c_BUF_DEPTH);
   localparam ptr_t               c_FULL_XOR  = {1'b1, {ADDR_WIDTH{1'b0}}};

   ptr_t                  r_wr_ptr;
   ptr_t                  r_rd_ptr;
   ptr_t                  w_wr_ptr_next;
   ptr_t                  w_rd_ptr_next;
   logic                  r_s_ready;
   logic [c_LAT-1:0]      r_rd_vld;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_rd_en;
   logic                  w_capture;
   logic                  w_buf_valid;
   logic [DATA_WIDTH-1:0] w_buf_dout;
   logic [c_CNT_W-1:0]    w_buf_cnt;
   logic [c_CNT_W-1:0]    w_inflight;
   logic [c_CNT_W-1:0]    w_credit_used;

   assign w_push = cke & s_valid & r_s_ready;
   assign w_pop  = cke & w_buf_valid & m_ready;

   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < c_LAT; i++) begin
         w_inflight = w_inflight + c_CNT_W'(r_rd_vld[i]);
      end
   end

   // The word leaving the buffer this cycle frees its slot, which is what
   // lets reads issue every cycle while the consumer keeps up.
   assign w_credit_used = w_inflight + w_buf_cnt - c_CNT_W'(w_pop);

   // r_wr_ptr only covers words written on earlier edges, so a read never
   // targets the address being written this cycle.
   assign w_rd_en = cke & (r_wr_ptr != r_rd_ptr) & (w_credit_used < c_CREDIT);

   assign w_wr_ptr_next = r_wr_ptr + ptr_t'(w_push);
   assign w_rd_ptr_next = r_rd_ptr + ptr_t'(w_rd_en);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_s_ready <= 1'b0;
      end else if (cke) begin
         r_wr_ptr  <= w_wr_ptr_next;
         r_rd_ptr  <= w_rd_ptr_next;
         r_s_ready <= ((w_wr_ptr_next ^ w_rd_ptr_next) != c_FULL_XOR);
      end
   end

   if (c_LAT == 1) begin : g_vld_lat1
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_rd_vld <= '0;
         end else if (cke) begin
            r_rd_vld <= w_rd_en;
         end
      end
   end else begin : g_vld_shift
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_rd_vld <= '0;
         end else if (cke) begin
            r_rd_vld <= {r_rd_vld[c_LAT-2:0], w_rd_en};
         end
      end
   end

   assign w_capture = r_rd_vld[c_LAT-1];

   jelly2_fifo_ram_ctrl_outbuf #(
      .DEPTH      (c_BUF_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_outbuf (
      .clk     (clk),
      .reset_n (reset_n),
      .cke     (cke),
      .capture (w_capture),
      .din     (ram_rd_dout),
      .pop     (w_pop),
      .dout    (w_buf_dout),
      .valid   (w_buf_valid),
      .count   (w_buf_cnt)
   );

`ifdef JELLY2_FIFO_RAM_CTRL_COUNT_EN
   ptr_t r_data_count;
   ptr_t r_free_count;
   ptr_t w_ram_used;

   assign w_ram_used = r_wr_ptr - r_rd_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data_count <= '0;
         r_free_count <= c_FULL_XOR;
      end else if (cke) begin
         r_data_count <= w_ram_used + ptr_t'(w_inflight) + ptr_t'(w_buf_cnt);
         r_free_count <= c_FULL_XOR - w_ram_used;
      end
   end

   assign data_count = r_data_count;
   assign free_count = r_free_count;
`endif

   assign s_ready       = r_s_ready;
   assign m_data        = w_buf_dout;
   assign m_valid       = w_buf_valid;
   assign ram_wr_en     = w_push;
   assign ram_wr_addr   = r_wr_ptr[ADDR_WIDTH-1:0];
   assign ram_wr_din    = s_data;
   assign ram_rd_en     = w_rd_en;
   assign ram_rd_regcke = cke;
   assign ram_rd_addr   = r_rd_ptr[ADDR_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_jelly2_fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jelly2_fifo_ram_ctrl
//  Description : Two controllers (DOUT_REGS 0 and 1, AW=3) on behavioural
//                RAMs, driven in lockstep and checked against scoreboards.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_jelly2_fifo_ram_ctrl;

   logic            clk;
   logic            reset_n;
   logic            cke;
   logic [7:0]      s_data;
   logic            s_valid;
   logic            m_ready;
   logic [1:0]      s_ready_v;
   logic [1:0][7:0] m_data_v;
   logic [1:0]      m_valid_v;
   logic [1:0]      ram_wr_en_v;
   logic [1:0][2:0] ram_wr_addr_v;
   logic [1:0][7:0] ram_wr_din_v;
   logic [1:0]      ram_rd_en_v;
   logic [1:0]      ram_rd_regcke_v;
   logic [1:0][2:0] ram_rd_addr_v;
   logic [1:0][7:0] ram_rd_dout_v;
`ifdef JELLY2_FIFO_RAM_CTRL_COUNT_EN
   logic [1:0][3:0] data_count_v;
   logic [1:0][3:0] free_count_v;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      logic [7:0] mem [8];
      logic [7:0] rd_q;
      logic [7:0] out_q;

      always @(posedge clk) begin
         if (ram_wr_en_v[gi])     mem[ram_wr_addr_v[gi]] <= ram_wr_din_v[gi];
         if (ram_rd_en_v[gi])     rd_q  <= mem[ram_rd_addr_v[gi]];
         if (ram_rd_regcke_v[gi]) out_q <= rd_q;
      end

      if (gi == 0) begin : g_lat1
         assign ram_rd_dout_v[gi] = rd_q;
      end else begin : g_lat2
         assign ram_rd_dout_v[gi] = out_q;
      end

      jelly2_fifo_ram_ctrl #(
         .ADDR_WIDTH (3),
         .DATA_WIDTH (8),
         .DOUT_REGS  (gi)
      ) u_dut (
         .reset_n       (reset_n),
         .clk           (clk),
         .cke           (cke),
         .s_data        (s_data),
         .s_valid       (s_valid),
         .s_ready       (s_ready_v[gi]),
         .m_data        (m_data_v[gi]),
         .m_valid       (m_valid_v[gi]),
         .m_ready       (m_ready),
         .ram_wr_en     (ram_wr_en_v[gi]),
         .ram_wr_addr   (ram_wr_addr_v[gi]),
         .ram_wr_din    (ram_wr_din_v[gi]),
         .ram_rd_en     (ram_rd_en_v[gi]),
         .ram_rd_regcke (ram_rd_regcke_v[gi]),
         .ram_rd_addr   (ram_rd_addr_v[gi]),
         .ram_rd_dout   (ram_rd_dout_v[gi])
`ifdef JELLY2_FIFO_RAM_CTRL_COUNT_EN
         ,
         .data_count    (data_count_v[gi]),
         .free_count    (free_count_v[gi])
`endif
      );
   end

   int              n_vec;
   int              n_err;
   int              cyc;
   int              mark;
   int              acc   [2];
   int              pops  [2];
   int              first_v [2];
   byte unsigned    sb0 [$];
   byte unsigned    sb1 [$];
   logic [1:0]      hold_v;
   logic [1:0][7:0] hold_d;

   task automatic check(input string tag, input int inst,
                        input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s[%0d]: observed %0h expected %0h", tag, inst, obs, exp);
      end
   endtask

   // One clock: check/score the handshakes of the current cycle at the
   // falling edge, then advance past the rising edge.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         logic       exp_wr;
         logic [7:0] exp_d;
         exp_wr = s_valid & s_ready_v[i] & cke;
         check("ram_wr_en", i, ram_wr_en_v[i], exp_wr);
         check("ram_rd_regcke", i, ram_rd_regcke_v[i], cke);
         if (hold_v[i]) begin
            check("m_valid_hold", i, m_valid_v[i], 1);
            check("m_data_hold", i, m_data_v[i], hold_d[i]);
         end
         if (m_valid_v[i] && first_v[i] < 0) first_v[i] = cyc;
         if (exp_wr) begin
            acc[i]++;
            if (i == 0) sb0.push_back(s_data);
            else        sb1.push_back(s_data);
         end
         if (m_valid_v[i] && m_ready && cke) begin
            pops[i]++;
            check("sb_nonempty", i, ((i == 0) ? sb0.size() : sb1.size()) > 0, 1);
            if (i == 0 && sb0.size() > 0) begin
               exp_d = sb0.pop_front();
               check("m_data", i, m_data_v[i], exp_d);
            end else if (i == 1 && sb1.size() > 0) begin
               exp_d = sb1.pop_front();
               check("m_data", i, m_data_v[i], exp_d);
            end
         end
         hold_v[i] = m_valid_v[i] & ~(m_ready & cke);
         hold_d[i] = m_data_v[i];
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      cyc     = 0;
      hold_v  = '0;
      hold_d  = '0;
      reset_n = 1'b0;
      cke     = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         acc[i] = 0; pops[i] = 0; first_v[i] = -1;
      end

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_s_ready", i, s_ready_v[i], 0);
         check("rst_m_valid", i, m_valid_v[i], 0);
         check("rst_m_data", i, m_data_v[i], 0);
`ifdef JELLY2_FIFO_RAM_CTRL_COUNT_EN
         check("rst_data_count", i, data_count_v[i], 0);
         check("rst_free_count", i, free_count_v[i], 8);
`endif
      end
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 2; i++) check("s_ready_after_reset", i, s_ready_v[i], 1);

      // Five back-to-back words, consumer always ready
      m_ready = 1'b1;
      mark    = cyc;
      for (int k = 0; k < 15; k++) begin
         s_valid = (k < 5);
         s_data  = 8'(k + 1);
         step();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("first_latency", i, first_v[i] - mark, 2 + 1 + i);
         check("burst_pops", i, pops[i], 5);
      end
      check("burst_drained", 0, sb0.size(), 0);
      check("burst_drained", 1, sb1.size(), 0);

      // Fill: buffer takes LAT+1 words, RAM takes 8 more, then stall
      m_ready = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < 2; i++) acc[i] = 0;
      for (int k = 0; k < 20; k++) begin
         s_data = 8'(8'h40 + k);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         check("fill_accepted", i, acc[i], 8 + 1 + i + 1);
         check("full_s_ready", i, s_ready_v[i], 0);
         check("full_m_valid", i, m_valid_v[i], 1);
         check("full_reject", i, ram_wr_en_v[i], 0);
      end

      // Stream from full: one word per clock on both sides
      m_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         acc[i] = 0; pops[i] = 0;
      end
      for (int k = 0; k < 64; k++) begin
         s_data = 8'(8'h80 + k);
         step();
      end
      for (int i = 0; i < 2; i++) begin
         check("stream_pops", i, pops[i], 64);
         check("stream_pushes", i, acc[i], 63);
      end
      s_valid = 1'b0;
      repeat (25) step();
      check("stream_drained", 0, sb0.size(), 0);
      check("stream_drained", 1, sb1.size(), 0);

      // Random traffic with clock-enable gaps
      for (int k = 0; k < 10000; k++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = 8'($urandom_range(0, 255));
         m_ready = ($urandom_range(0, 99) < 55);
         cke     = ($urandom_range(0, 9) != 0);
         step();
      end
      cke     = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b1;
      repeat (30) step();
      for (int i = 0; i < 2; i++) check("rand_m_valid_idle", i, m_valid_v[i], 0);
      check("rand_drained", 0, sb0.size(), 0);
      check("rand_drained", 1, sb1.size(), 0);

      // Reset mid-stream with five words stored
      m_ready = 1'b0;
      s_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         s_data = 8'(8'hA0 + k);
         step();
      end
      s_valid = 1'b0;
      repeat (3) step();
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("midrst_m_valid", i, m_valid_v[i], 0);
         check("midrst_s_ready", i, s_ready_v[i], 0);
      end
      sb0.delete();
      sb1.delete();
      hold_v = '0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
`ifdef JELLY2_FIFO_RAM_CTRL_COUNT_EN
      for (int i = 0; i < 2; i++) begin
         check("post_rst_data_count", i, data_count_v[i], 0);
         check("post_rst_free_count", i, free_count_v[i], 8);
      end
`endif
      m_ready = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'hC0;
      for (int i = 0; i < 2; i++) begin
         check("post_rst_wr_addr", i, ram_wr_addr_v[i], 0);
         pops[i] = 0; first_v[i] = -1;
      end
      mark = cyc;
      for (int k = 0; k < 12; k++) begin
         s_valid = (k < 3);
         s_data  = 8'(8'hC0 + k);
         step();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("post_rst_latency", i, first_v[i] - mark, 2 + 1 + i);
         check("post_rst_pops", i, pops[i], 3);
      end
      check("post_rst_drained", 0, sb0.size(), 0);
      check("post_rst_drained", 1, sb1.size(), 0);

`ifdef JELLY2_FIFO_RAM_CTRL_COUNT_EN
      // Push 3, pop 1; all remaining words settle into the output buffer
      m_ready = 1'b0;
      s_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         s_data = 8'(8'hD0 + k);
         step();
      end
      s_valid = 1'b0;
      repeat (4) step();
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      repeat (5) step();
      for (int i = 0; i < 2; i++) begin
         check("cnt_data_count", i, data_count_v[i], 2);
         check("cnt_free_count", i, free_count_v[i], 8);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
